// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types for the unified memory arbiter: FSM state and
//                access-owner encodings, plus a helper that sizes the
//                latency down-counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // Counter width able to hold MEM_LAT-1, with one spare bit so that a
    // latency of 1 still yields a legal 1-bit vector.
    function automatic int cnt_width(input int lat);
        return $clog2(lat) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/unified_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : unified_mem_arbiter_if
//  Description : Bundle of the fetch requester, data requester and memory
//                signals around the unified memory arbiter.
//                slave  : arbiter view (requests/mem_rdata in, rest out)
//                master : environment view (requesters and memory)
//  Revision    : 1.0 - initial release
// ============================================================================
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              if_stall;
    // data requester
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    logic              d_stall;
    // memory
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pick
//  Description : Combinational winner select for the unified memory arbiter.
//                A requester whose completion pulse is high this cycle is
//                still presenting its finished request and is masked out.
//                Data wins conflicts unless the starvation guard reports a
//                full data streak (ARB_STARVE_GUARD_EN builds only).
//  Ports       : i_if_req/i_if_valid   fetch request and completion pulse
//                i_d_req/i_d_valid     data request and completion pulse
//                i_streak_full         data streak at limit (guard build)
//                o_grant               some requester is eligible
//                o_owner               winning requester
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  wire logic i_if_req,
    input  wire logic i_if_valid,
    input  wire logic i_d_req,
    input  wire logic i_d_valid,
`ifdef ARB_STARVE_GUARD_EN
    input  wire logic i_streak_full,
`endif
    output logic      o_grant,
    output owner_t    o_owner
);

    logic w_if_elig;
    logic w_d_elig;
    logic w_d_wins;

    assign w_if_elig = i_if_req & ~i_if_valid;
    assign w_d_elig  = i_d_req  & ~i_d_valid;

`ifdef ARB_STARVE_GUARD_EN
    // Fetch overrides data only when both compete and the streak is full.
    assign w_d_wins = w_d_elig & ~(w_if_elig & i_streak_full);
`else
    assign w_d_wins = w_d_elig;
`endif

    assign o_grant = w_if_elig | w_d_elig;
    assign o_owner = w_d_wins ? OWN_D : OWN_IF;

endmodule
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : unified_mem_arbiter
//  Description : Shares one single-port memory between the fetch and data
//                stages. Each access is latched in IDLE, issued for exactly
//                one cycle, waits MEM_LAT cycles and returns data through a
//                registered rdata plus a one-cycle valid pulse. Stall lines
//                hold the requesting pipeline stage until completion.
//  Ports       : clk, rst   clock and synchronous active-high reset
//                bus        unified_mem_arbiter_if.slave (requesters+memory)
//  Config      : ARB_STARVE_GUARD_EN - when defined, a fetch that has watched
//                STARVE_MAX consecutive data grants wins the next conflict.
//  Revision    : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,
    unified_mem_arbiter_if.slave bus
);

    localparam int                 c_CNT_W    = cnt_width(MEM_LAT);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MEM_LAT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    state_t              r_state;
    owner_t              r_owner;
    logic                r_we;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_if_rdata;
    logic                r_if_valid;
    logic [DATA_W-1:0]   r_d_rdata;
    logic                r_d_valid;

    logic                w_grant;
    owner_t              w_owner;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic                w_sel_we;
    logic [DATA_W-1:0]   w_sel_wdata;

`ifdef ARB_STARVE_GUARD_EN
    localparam int                    c_STREAK_W   = $clog2(STARVE_MAX + 1);
    localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(STARVE_MAX);
    localparam logic [c_STREAK_W-1:0] c_STREAK_ONE = c_STREAK_W'(1);

    logic [c_STREAK_W-1:0] r_streak;
    logic                  w_streak_full;

    assign w_streak_full = (r_streak == c_STREAK_MAX);
`else
    // Strict data priority: STARVE_MAX has no effect in this build.
    if (STARVE_MAX < 0) begin : g_starve_unused
    end
`endif

    mem_arb_pick u_pick (
        .i_if_req      (bus.if_req),
        .i_if_valid    (r_if_valid),
        .i_d_req       (bus.d_req),
        .i_d_valid     (r_d_valid),
`ifdef ARB_STARVE_GUARD_EN
        .i_streak_full (w_streak_full),
`endif
        .o_grant       (w_grant),
        .o_owner       (w_owner)
    );

    // Request fields of the winner; a fetch never writes.
    assign w_sel_addr  = (w_owner == OWN_D) ? bus.d_addr : bus.if_addr;
    assign w_sel_we    = (w_owner == OWN_D) & bus.d_we;
    assign w_sel_wdata = (w_owner == OWN_D) ? bus.d_wdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_IF;
            r_we        <= 1'b0;
            r_cnt       <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_if_valid  <= 1'b0;
            r_d_rdata   <= '0;
            r_d_valid   <= 1'b0;
`ifdef ARB_STARVE_GUARD_EN
            r_streak    <= '0;
`endif
        end else begin
            // Pulses and the memory strobe default low; only the
            // transitions below raise them for a single cycle.
            r_if_valid  <= 1'b0;
            r_d_valid   <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;

            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        // Latching here decouples the access from later
                        // request drops or address changes.
                        r_owner     <= w_owner;
                        r_we        <= w_sel_we;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= w_sel_we;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                        r_state     <= ST_ISSUE;
`ifdef ARB_STARVE_GUARD_EN
                        if (w_owner == OWN_IF || !bus.if_req) begin
                            r_streak <= '0;
                        end else if (r_streak != c_STREAK_MAX) begin
                            r_streak <= r_streak + c_STREAK_ONE;
                        end
`endif
                    end
                end

                ST_ISSUE: begin
                    r_cnt   <= c_CNT_LOAD;
                    r_state <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        if (r_owner == OWN_D) begin
                            r_d_valid <= 1'b1;
                            if (!r_we) begin
                                r_d_rdata <= bus.mem_rdata;
                            end
                        end else begin
                            r_if_valid <= 1'b1;
                            r_if_rdata <= bus.mem_rdata;
                        end
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.if_valid  = r_if_valid;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.d_valid   = r_d_valid;

    // Stalls release in the completion cycle so the stage advances with it.
    assign bus.if_stall  = bus.if_req & ~r_if_valid;
    assign bus.d_stall   = bus.d_req  & ~r_d_valid;

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_unified_mem_arbiter
//  Description : Self-checking bench for unified_mem_arbiter. Instance u_dut0
//                runs MEM_LAT=2 / STARVE_MAX=2, instance u_dut1 MEM_LAT=1.
//                Each has a small memory model that drives mem_rdata only in
//                the cycle the data is defined, 16'hDEAD otherwise.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_unified_mem_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    unified_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) ifc0 ();
    unified_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) ifc1 ();

    unified_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2), .STARVE_MAX(2)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (ifc0.slave)
    );

    unified_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (ifc1.slave)
    );

    // ---------------- memory models ----------------
    logic [15:0] mem0 [0:255];
    logic [15:0] mem1 [0:255];
    logic [15:0] rd0_q = 16'h0;
    logic [15:0] rd1_q = 16'h0;
    int          rd0_cnt = 0;
    int          rd1_cnt = 0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 16'hB000 | 16'(i);
            mem1[i] = 16'hB000 | 16'(i);
        end
        mem0[8'h10] = 16'hA5A5;
    end

    always @(posedge clk) begin
        if (ifc0.mem_en) begin
            rd0_q   <= mem0[ifc0.mem_addr[7:0]];
            rd0_cnt <= 2;
            if (ifc0.mem_we) mem0[ifc0.mem_addr[7:0]] = ifc0.mem_wdata;
        end else if (rd0_cnt > 0) begin
            rd0_cnt <= rd0_cnt - 1;
        end
    end

    always @(posedge clk) begin
        if (ifc1.mem_en) begin
            rd1_q   <= mem1[ifc1.mem_addr[7:0]];
            rd1_cnt <= 1;
            if (ifc1.mem_we) mem1[ifc1.mem_addr[7:0]] = ifc1.mem_wdata;
        end else if (rd1_cnt > 0) begin
            rd1_cnt <= rd1_cnt - 1;
        end
    end

    assign ifc0.mem_rdata = (rd0_cnt == 1) ? rd0_q : 16'hDEAD;
    assign ifc1.mem_rdata = (rd1_cnt == 1) ? rd1_q : 16'hDEAD;

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          is_d;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;  // owner's rdata after completion
    } vec_t;

    vec_t vecs [8];

    // Single isolated access on u_dut0: issue at T+1, valid at T+4.
    task automatic run_vec(input int idx, input vec_t v);
        string p;
        p = $sformatf("v%0d", idx);
        @(negedge clk);
        if (v.is_d) begin
            ifc0.d_req   = 1'b1;
            ifc0.d_we    = v.we;
            ifc0.d_addr  = v.addr;
            ifc0.d_wdata = v.wdata;
        end else begin
            ifc0.if_req  = 1'b1;
            ifc0.if_addr = v.addr;
        end
        #1;
        check({p, "_stall_T"}, v.is_d ? ifc0.d_stall : ifc0.if_stall, 1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("%s_mem_en_k%0d", p, k), ifc0.mem_en, (k == 1) ? 1 : 0);
            if (k == 1) begin
                check({p, "_mem_we"},   ifc0.mem_we,   v.we);
                check({p, "_mem_addr"}, ifc0.mem_addr, v.addr);
                if (v.we) check({p, "_mem_wdata"}, ifc0.mem_wdata, v.wdata);
            end
            check($sformatf("%s_valid_k%0d", p, k),
                  v.is_d ? ifc0.d_valid : ifc0.if_valid, (k == 4) ? 1 : 0);
            if (k < 4) begin
                check($sformatf("%s_stall_k%0d", p, k),
                      v.is_d ? ifc0.d_stall : ifc0.if_stall, 1);
            end
            if (k == 4) begin
                check({p, "_rdata"}, v.is_d ? ifc0.d_rdata : ifc0.if_rdata, v.exp_rdata);
                check({p, "_stall_done"}, v.is_d ? ifc0.d_stall : ifc0.if_stall, 0);
                ifc0.d_req  = 1'b0;
                ifc0.if_req = 1'b0;
            end
        end
    endtask

    initial begin
        logic       g [3];
        int         ng;
        logic       exp_third;

        vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hA5A5};
        vecs[1] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'hB020};
        vecs[2] = '{1'b1, 1'b1, 16'h0030, 16'h1234, 16'hB020};
        vecs[3] = '{1'b1, 1'b0, 16'h0030, 16'h0000, 16'h1234};
        vecs[4] = '{1'b0, 1'b0, 16'h00FF, 16'h0000, 16'hB0FF};
        vecs[5] = '{1'b1, 1'b1, 16'h0044, 16'hFFFF, 16'h1234};
        vecs[6] = '{1'b1, 1'b0, 16'h0044, 16'h0000, 16'hFFFF};
        vecs[7] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'hB000};

        rst = 1'b1;
        ifc0.if_req = 1'b0; ifc0.if_addr = '0; ifc0.d_req = 1'b0;
        ifc0.d_we = 1'b0;   ifc0.d_addr = '0;  ifc0.d_wdata = '0;
        ifc1.if_req = 1'b0; ifc1.if_addr = '0; ifc1.d_req = 1'b0;
        ifc1.d_we = 1'b0;   ifc1.d_addr = '0;  ifc1.d_wdata = '0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_mem_en",    ifc0.mem_en,    0);
        check("rst_mem_we",    ifc0.mem_we,    0);
        check("rst_mem_addr",  ifc0.mem_addr,  0);
        check("rst_mem_wdata", ifc0.mem_wdata, 0);
        check("rst_if_valid",  ifc0.if_valid,  0);
        check("rst_d_valid",   ifc0.d_valid,   0);
        check("rst_if_rdata",  ifc0.if_rdata,  0);
        check("rst_d_rdata",   ifc0.d_rdata,   0);
        check("rst_stalls",    {ifc0.if_stall, ifc0.d_stall}, 0);
        rst = 1'b0;

        // table-driven single accesses
        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // conflict: data issued T+1, d_valid T+4; fetch issued T+5, if_valid T+8
        @(negedge clk);
        ifc0.d_req = 1'b1; ifc0.d_we = 1'b0; ifc0.d_addr = 16'h0020;
        ifc0.if_req = 1'b1; ifc0.if_addr = 16'h0012;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check($sformatf("cf_mem_en_k%0d", k), ifc0.mem_en, (k == 1 || k == 5) ? 1 : 0);
            if (k == 1) check("cf_addr_d",  ifc0.mem_addr, 16'h0020);
            if (k == 5) check("cf_addr_if", ifc0.mem_addr, 16'h0012);
            check($sformatf("cf_d_valid_k%0d", k),  ifc0.d_valid,  (k == 4) ? 1 : 0);
            check($sformatf("cf_if_valid_k%0d", k), ifc0.if_valid, (k == 8) ? 1 : 0);
            if (k == 4) begin
                check("cf_d_rdata", ifc0.d_rdata, 16'hB020);
                check("cf_if_stall_held", ifc0.if_stall, 1);
                ifc0.d_req = 1'b0;
            end
            if (k == 8) begin
                check("cf_if_rdata", ifc0.if_rdata, 16'hB012);
                ifc0.if_req = 1'b0;
            end
        end

        // reset during the first WAIT cycle abandons the access
        @(negedge clk);
        ifc0.if_req = 1'b1; ifc0.if_addr = 16'h0010;
        @(negedge clk);
        check("rw_issue", ifc0.mem_en, 1);
        @(negedge clk);
        rst = 1'b1; ifc0.if_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rw_mem_en",   ifc0.mem_en,   0);
        check("rw_mem_addr", ifc0.mem_addr, 0);
        check("rw_if_valid", ifc0.if_valid, 0);
        check("rw_if_rdata", ifc0.if_rdata, 0);
        check("rw_d_rdata",  ifc0.d_rdata,  0);
        ng = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ifc0.if_valid || ifc0.mem_en) ng++;
        end
        check("rw_no_late_activity", ng, 0);

        // held data load with a fetch that backs off during each d_valid cycle
`ifdef ARB_STARVE_GUARD_EN
        exp_third = 1'b0;
`else
        exp_third = 1'b1;
`endif
        @(negedge clk);
        ifc0.d_req = 1'b1; ifc0.d_we = 1'b0; ifc0.d_addr = 16'h0020;
        ifc0.if_req = 1'b1; ifc0.if_addr = 16'h0012;
        ng = 0;
        for (int k = 0; k < 40 && ng < 3; k++) begin
            @(negedge clk);
            if (ifc0.mem_en) begin
                g[ng] = (ifc0.mem_addr != 16'h0012);
                ng++;
            end
            ifc0.if_req = ~ifc0.d_valid;
        end
        check("sg_grant_count", ng, 3);
        if (ng == 3) begin
            check("sg_grant0_d", g[0], 1);
            check("sg_grant1_d", g[1], 1);
            check("sg_grant2",   g[2], exp_third);
        end
        ifc0.d_req = 1'b0; ifc0.if_req = 1'b0;
        repeat (8) @(negedge clk);

        // MEM_LAT=1: back-to-back fetches on u_dut1
        @(negedge clk);
        ifc1.if_req = 1'b1; ifc1.if_addr = 16'h0000;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check($sformatf("l1_mem_en_k%0d", k), ifc1.mem_en, (k == 1 || k == 5) ? 1 : 0);
            check($sformatf("l1_if_valid_k%0d", k), ifc1.if_valid, (k == 3 || k == 7) ? 1 : 0);
            if (k == 5) check("l1_addr2", ifc1.mem_addr, 16'h0002);
            if (k == 3) begin
                check("l1_rdata0", ifc1.if_rdata, 16'hB000);
                ifc1.if_addr = 16'h0002;
            end
            if (k == 7) begin
                check("l1_rdata2", ifc1.if_rdata, 16'hB002);
                ifc1.if_req = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
